// File: rtl/loader_defs.sv
// rtl/loader_defs.sv - shared constants and state encodings for the UART ROM loader
// Contents: loader FSM states, receiver FSM states, protocol widths, default bit period.
package loader_defs;

    localparam int CNT_W           = 16;   // image word count field width
    localparam int BYTES_PER_WORD  = 4;
    localparam int DEFAULT_CLK_DIV = 434;  // 50 MHz / 115200 baud

    typedef enum logic [1:0] {
        CNT_HI,
        CNT_LO,
        DATA,
        DONE
    } load_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - 8N1 UART byte receiver with synchroniser and framing check
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   uart_rx      : serial input, idle high, asynchronous to clk
//   byte_valid   : one-cycle pulse in the stop-bit centre cycle of a good frame
//   byte_data    : received byte, valid with byte_valid
//   frame_err    : one-cycle pulse when the stop bit samples low
module uart_rx_byte
    import loader_defs::*;
#(
    parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int HALF = CLK_DIV / 2;

    logic        rx_meta;
    logic        rx_sync;
    logic        rx_prev;
    rx_state_t   rx_state;
    rx_state_t   rx_next;
    logic [15:0] cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shift;
    logic        half_hit;
    logic        bit_hit;

    assign half_hit = (rx_state == RX_START) && (cnt == 16'(HALF - 1));
    assign bit_hit  = ((rx_state == RX_DATA) || (rx_state == RX_STOP)) &&
                      (cnt == 16'(CLK_DIV - 1));

    // Synchroniser and edge history reset to the idle-high line level so
    // reset release never looks like a start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state <= RX_IDLE;
        end else begin
            rx_state <= rx_next;
        end
    end

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE:      if (rx_prev && !rx_sync) rx_next = RX_START;
            // A start bit that is high again at half a bit was a glitch.
            RX_START:     if (half_hit) rx_next = rx_sync ? RX_IDLE : RX_DATA;
            RX_DATA:      if (bit_hit && (bit_idx == 3'd7)) rx_next = RX_STOP;
            RX_STOP:      if (bit_hit) rx_next = rx_sync ? RX_IDLE : RX_WAIT_HIGH;
            // After a framing error, only re-arm once the line is back high.
            RX_WAIT_HIGH: if (rx_sync) rx_next = RX_IDLE;
            default:      rx_next = RX_IDLE;
        endcase
    end

    always_comb begin
        byte_valid = 1'b0;
        frame_err  = 1'b0;
        if ((rx_state == RX_STOP) && bit_hit) begin
            byte_valid = rx_sync;
            frame_err  = !rx_sync;
        end
    end

    // Bit-period counter restarts at each sample point so later samples stay
    // centred relative to the half-bit start check.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            if ((rx_state == RX_IDLE) || (rx_state == RX_WAIT_HIGH) || half_hit || bit_hit) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 16'd1;
            end
            if (rx_state == RX_START) begin
                bit_idx <= '0;
            end else if ((rx_state == RX_DATA) && bit_hit) begin
                shift   <= {rx_sync, shift[7:1]};
                bit_idx <= bit_idx + 3'd1;
            end
        end
    end

    assign byte_data = shift;

endmodule

// File: rtl/rom_uart_loader.sv
// rtl/rom_uart_loader.sv - boot loader writing a UART-delivered image into the instruction ROM
// Optional feature macro: LOADER_TIMEOUT_EN (idle timeout with TIMEOUT_CYC parameter).
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   uart_rx    : serial image input (count hi, count lo, then little-endian words)
//   rom_we     : one-cycle ROM write strobe
//   rom_waddr  : ROM word address, held between writes
//   rom_wdata  : ROM write data, held between writes
//   load_done  : image complete, sticky until rst
//   load_err   : framing / overflow / timeout error, sticky until rst
module rom_uart_loader
    import loader_defs::*;
#(
    parameter int CLK_DIV     = DEFAULT_CLK_DIV,
`ifdef LOADER_TIMEOUT_EN
    parameter int TIMEOUT_CYC = 5_000_000,
`endif
    parameter int ADDR_W      = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              uart_rx,
    output logic              rom_we,
    output logic [ADDR_W-1:0] rom_waddr,
    output logic [31:0]       rom_wdata,
    output logic              load_done,
    output logic              load_err
);

    logic             byte_valid;
    logic [7:0]       byte_data;
    logic             frame_err;
    load_state_t      state;
    load_state_t      state_next;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] word_cnt;
    logic [1:0]       byte_idx;
    logic [23:0]      word_buf;
    logic             last_byte;
    logic             overflow;
    logic             timeout;

    uart_rx_byte #(
        .CLK_DIV (CLK_DIV)
    ) u_rx (
        .clk        (clk),
        .rst        (rst),
        .uart_rx    (uart_rx),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .frame_err  (frame_err)
    );

    assign last_byte = (byte_idx == 2'(BYTES_PER_WORD - 1));
    // Words past the ROM depth are consumed but never written, so addresses
    // cannot wrap onto locations already loaded.
    assign overflow  = ((32'(word_cnt) >> ADDR_W) != 32'd0);

`ifdef LOADER_TIMEOUT_EN
    logic [31:0] idle_cnt;
    logic        waiting;

    assign waiting = (state == CNT_LO) || (state == DATA);
    assign timeout = waiting && !byte_valid && (idle_cnt == 32'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cnt <= '0;
        end else if (!waiting || byte_valid || timeout) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 32'd1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= CNT_HI;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (timeout) begin
            state_next = CNT_HI;
        end else if (byte_valid) begin
            case (state)
                CNT_HI:  state_next = CNT_LO;
                CNT_LO:  state_next = ({count[15:8], byte_data} == '0) ? DONE : DATA;
                DATA:    if (last_byte && (CNT_W'(word_cnt + 1'b1) == count)) state_next = DONE;
                default: state_next = DONE;
            endcase
        end
    end

    always_comb begin
        load_done = (state == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count     <= '0;
            word_cnt  <= '0;
            byte_idx  <= '0;
            word_buf  <= '0;
            rom_we    <= 1'b0;
            rom_waddr <= '0;
            rom_wdata <= '0;
            load_err  <= 1'b0;
        end else begin
            rom_we <= 1'b0;
            if (timeout) begin
                load_err  <= 1'b1;
                word_cnt  <= '0;
                byte_idx  <= '0;
                word_buf  <= '0;
                rom_waddr <= '0;
            end else if (state != DONE) begin
                if (frame_err) begin
                    load_err <= 1'b1;
                end
                if (byte_valid) begin
                    case (state)
                        CNT_HI: count[15:8] <= byte_data;
                        CNT_LO: begin
                            count[7:0] <= byte_data;
                            word_cnt   <= '0;
                            byte_idx   <= '0;
                        end
                        DATA: begin
                            if (last_byte) begin
                                byte_idx <= '0;
                                word_cnt <= word_cnt + 1'b1;
                                if (overflow) begin
                                    load_err <= 1'b1;
                                end else begin
                                    rom_we    <= 1'b1;
                                    rom_waddr <= word_cnt[ADDR_W-1:0];
                                    rom_wdata <= {byte_data, word_buf};
                                end
                            end else begin
                                case (byte_idx)
                                    2'd0:    word_buf[7:0]   <= byte_data;
                                    2'd1:    word_buf[15:8]  <= byte_data;
                                    default: word_buf[23:16] <= byte_data;
                                endcase
                                byte_idx <= byte_idx + 2'd1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_rom_uart_loader.sv
// tb/tb_rom_uart_loader.sv - directed scoreboard bench for rom_uart_loader
module tb_rom_uart_loader;
    import loader_defs::*;

    localparam int CLK_DIV = 4;
    localparam int ADDR_W  = 2;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        done;
    } wr_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              uart_rx = 1'b1;
    logic              rom_we;
    logic [ADDR_W-1:0] rom_waddr;
    logic [31:0]       rom_wdata;
    logic              load_done;
    logic              load_err;

    int  checks = 0;
    int  failures = 0;
    wr_t exp_q[$];

    always #5 clk = ~clk;

    rom_uart_loader #(
        .CLK_DIV     (CLK_DIV),
`ifdef LOADER_TIMEOUT_EN
        .TIMEOUT_CYC (100),
`endif
        .ADDR_W      (ADDR_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .uart_rx   (uart_rx),
        .rom_we    (rom_we),
        .rom_waddr (rom_waddr),
        .rom_wdata (rom_wdata),
        .load_done (load_done),
        .load_err  (load_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_wr(input logic [31:0] a, input logic [31:0] d, input logic dn);
        wr_t e;
        e.addr = a;
        e.data = d;
        e.done = dn;
        exp_q.push_back(e);
    endtask

    task automatic drive_bit(input logic v);
        uart_rx = v;
        repeat (CLK_DIV) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop_bit);
        uart_rx = 1'b1;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b1;
        uart_rx = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Settle window bounds every wait for a write; leftover entries fail.
    task automatic settle_and_drain(input string tag);
        repeat (4 * CLK_DIV) @(negedge clk);
        check({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    always @(negedge clk) begin
        if (!rst && rom_we) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                failures++;
                $error("FAIL unexpected_write observed addr=%h data=%h expected no write",
                       rom_waddr, rom_wdata);
            end
            if (exp_q.size() != 0) begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", 32'(rom_waddr), e.addr);
                check("wr_data", rom_wdata, e.data);
                check("wr_done", 32'(load_done), 32'(e.done));
            end
        end
    end

    initial begin
        // reset state
        repeat (3) @(negedge clk);
        check("rst_we", 32'(rom_we), 32'd0);
        check("rst_waddr", 32'(rom_waddr), 32'd0);
        check("rst_wdata", rom_wdata, 32'd0);
        check("rst_done", 32'(load_done), 32'd0);
        check("rst_err", 32'(load_err), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // two-word image
        push_wr(0, 32'h00100D93, 1'b0);
        push_wr(1, 32'h01CD8EB3, 1'b1);
        send_byte(8'h00);
        send_byte(8'h02);
        send_word(32'h00100D93);
        send_word(32'h01CD8EB3);
        settle_and_drain("img2");
        check("img2_done", 32'(load_done), 32'd1);
        check("img2_err", 32'(load_err), 32'd0);

        // traffic after DONE is ignored
        send_byte(8'h55, 1'b0);
        send_word(32'h12345678);
        settle_and_drain("post_done");
        check("post_done_err", 32'(load_err), 32'd0);

        // empty image
        do_reset();
        send_byte(8'h00);
        send_byte(8'h00);
        settle_and_drain("empty");
        check("empty_done", 32'(load_done), 32'd1);
        check("empty_err", 32'(load_err), 32'd0);

        // framing error drops one byte
        do_reset();
        push_wr(0, 32'h44332211, 1'b1);
        send_byte(8'h00);
        send_byte(8'h01);
        check("ferr_before", 32'(load_err), 32'd0);
        send_byte(8'hA5, 1'b0);
        repeat (3 * CLK_DIV) @(negedge clk);
        check("ferr_flag", 32'(load_err), 32'd1);
        send_word(32'h44332211);
        settle_and_drain("ferr");
        check("ferr_done", 32'(load_done), 32'd1);

        // overflow past 2^ADDR_W words
        do_reset();
        send_byte(8'h00);
        send_byte(8'h05);
        for (int i = 0; i < 4; i++) begin
            push_wr(i, 32'hA0B0C000 + i, 1'b0);
            send_word(32'hA0B0C000 + i);
        end
        settle_and_drain("ovf_fill");
        check("ovf_err_before", 32'(load_err), 32'd0);
        check("ovf_done_before", 32'(load_done), 32'd0);
        send_word(32'hDEADBEEF);
        settle_and_drain("ovf");
        check("ovf_err", 32'(load_err), 32'd1);
        check("ovf_done", 32'(load_done), 32'd1);
        check("ovf_addr_held", 32'(rom_waddr), 32'd3);

        // reset in the middle of a word
        do_reset();
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'hDE);
        send_byte(8'hAD);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_we", 32'(rom_we), 32'd0);
        check("abort_wdata", rom_wdata, 32'd0);
        check("abort_done", 32'(load_done), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        push_wr(0, 32'hCAFEF00D, 1'b1);
        send_byte(8'h00);
        send_byte(8'h01);
        send_word(32'hCAFEF00D);
        settle_and_drain("abort");
        check("abort_reload_done", 32'(load_done), 32'd1);
        check("abort_reload_err", 32'(load_err), 32'd0);

`ifdef LOADER_TIMEOUT_EN
        // idle timeout mid-word
        do_reset();
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h11);
        send_byte(8'h22);
        check("tmo_err_before", 32'(load_err), 32'd0);
        repeat (110) @(negedge clk);
        check("tmo_err", 32'(load_err), 32'd1);
        check("tmo_state", 32'(dut.state), 32'(CNT_HI));
        check("tmo_waddr", 32'(rom_waddr), 32'd0);
        push_wr(0, 32'h87654321, 1'b1);
        send_byte(8'h00);
        send_byte(8'h01);
        send_word(32'h87654321);
        settle_and_drain("tmo");
        check("tmo_done", 32'(load_done), 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
